// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int DEFAULT_OSR    = 16;
    localparam int DEFAULT_DATA_W = 8;
    localparam int FRAME_BITS     = DEFAULT_DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a
// configurable reset value so an idle-high line reads as idle out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: flops use non-blocking assignments so both stages capture the
    // pre-edge values; blocking here would collapse the chain to one flop.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start validation, centre sampling
// of data and stop bits, and a valid/ack output register with overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OSR    = DEFAULT_OSR,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rxd,
    input  logic              rxen,
    input  logic              rx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              overrun
);

    localparam int S_W = $clog2(OSR);
    localparam int B_W = $clog2(DATA_W) + 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OSR / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OSR - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(DATA_W - 1);

    logic              rxd_s;
    uart_state_e       state_q,     state_d;
    logic              armed_q,     armed_d;
    logic [S_W-1:0]    s_cnt_q,     s_cnt_d;
    logic [B_W-1:0]    b_cnt_q,     b_cnt_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic [DATA_W-1:0] rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;
    logic              frame_good;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d_i   (rxd),
        .q_o   (rxd_s)
    );

    // NOTE: every variable gets its hold value first, so branches that do
    // not mention it cannot infer a latch.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        s_cnt_d     = s_cnt_q;
        b_cnt_d     = b_cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = frame_err_q;
        frame_good  = 1'b0;

        if (rxen) begin
            case (state_q)
                ST_IDLE: begin
                    // A falling edge only counts once the line has been seen high.
                    if (rxd_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = ST_START;
                        s_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (s_cnt_q == S_MID) begin
                        if (rxd_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (s_cnt_q == S_LAST) begin
                        shreg_d = {rxd_s, shreg_q[DATA_W-1:1]};
                        b_cnt_d = b_cnt_q + 1'b1;
                        s_cnt_d = '0;
                        if (b_cnt_q == B_LAST) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (s_cnt_q == S_LAST) begin
                        state_d     = ST_IDLE;
                        armed_d     = 1'b0;
                        frame_err_d = ~rxd_s;
                        frame_good  = rxd_s;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;

        if (frame_good) begin
            if (!rx_valid_q || rx_ack) begin
                // An ack in the completion cycle frees the slot for the new byte.
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
                overrun_d  = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            s_cnt_q     <= '0;
            b_cnt_q     <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            s_cnt_q     <= s_cnt_d;
            b_cnt_q     <= b_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: timed corner-case sequences, a frame
// vector table, and random frames against a frame-level reference model.
module tb_uart_rx;

    localparam int OSR        = 16;
    localparam int DATA_W     = 8;
    localparam int BIT_CLK    = 64;
    localparam int DONE_TICKS = OSR / 2 + (DATA_W + 1) * OSR;
    localparam int N_VEC      = 7;
    localparam int N_RAND     = 30;

    logic              clk;
    logic              n_rst;
    logic              rxd;
    logic              rxen;
    logic              rx_ack;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_err;
    logic              overrun;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        bit         ack_after;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs [N_VEC];

    uart_rx #(
        .OSR    (OSR),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .rxen      (rxen),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample strobe: one clk wide, every 4th clk.
    initial begin
        rxen = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rxen = 1'b1;
            @(negedge clk);
            rxen = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                             input logic f, input logic o);
        check({tag, " rx_data"},   32'(rx_data),   32'(d));
        check({tag, " rx_valid"},  32'(rx_valid),  32'(v));
        check({tag, " frame_err"}, 32'(frame_err), 32'(f));
        check({tag, " overrun"},   32'(overrun),   32'(o));
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Follows the line as the receiver sees it (2 clk late), finds the start
    // detection tick and samples outputs on either side of the edge that ends
    // the stop-sample tick; optionally acks exactly in that cycle.
    task automatic watch_done(input bit drive_ack, output bit found, output logic pre_v,
                              output logic [7:0] pre_d, output logic post_v);
        logic h1, h2, seen;
        bit   det;
        int   ticks;
        h1 = 1'b1; h2 = 1'b1; det = 1'b0; ticks = 0;
        found = 1'b0; pre_v = 1'bx; pre_d = 'x; post_v = 1'bx;
        for (int c = 0; c < 4 * DONE_TICKS + 64 && !found; c++) begin
            @(posedge clk);
            seen = h2; h2 = h1; h1 = rxd;
            if (rxen) begin
                if (det) ticks++;
                else if (seen == 1'b0) det = 1'b1;
                if (det && ticks == DONE_TICKS - 1) begin
                    repeat (4) @(negedge clk);
                    pre_v = rx_valid;
                    pre_d = rx_data;
                    if (drive_ack) rx_ack = 1'b1;
                    @(negedge clk);
                    rx_ack = 1'b0;
                    post_v = rx_valid;
                    found  = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bit         found;
        logic       pre_v, post_v;
        logic [7:0] pre_d;
        logic [7:0] m_data, r_data;
        logic       m_valid, m_ferr, m_ovr, r_stop;

        vecs[0] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hC3, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1};

        n_rst  = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        repeat (4) @(negedge clk);
        n_rst = 1'b1;
        check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        idle(8);

        // Single frame with exact completion timing, then ack.
        fork
            send_frame(8'hA5, 1'b1);
            watch_done(1'b0, found, pre_v, pre_d, post_v);
        join
        check("a5 completion found", 32'(found), 32'd1);
        check("a5 valid before stop edge", 32'(pre_v), 32'd0);
        check("a5 valid after stop edge", 32'(post_v), 32'd1);
        check_out("a5 frame", 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(8);
        pulse_ack();
        check_out("a5 after ack", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Short low glitch on idle line: rejected at start centre.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        idle(2 * BIT_CLK);
        check_out("glitch", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Frame vector table.
        for (int i = 0; i < N_VEC; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                      vecs[i].exp_ferr, vecs[i].exp_ovr);
            idle(BIT_CLK);
            if (vecs[i].ack_after) begin
                pulse_ack();
                check($sformatf("vec%0d ack valid", i), 32'(rx_valid), 32'd0);
                check($sformatf("vec%0d ack overrun", i), 32'(overrun), 32'd0);
            end
        end

        // Framing error followed by a long break, then a good frame.
        send_frame(8'h3C, 1'b0);
        check_out("ferr frame", 8'h01, 1'b0, 1'b1, 1'b0);
        rxd = 1'b0;
        repeat (30 * BIT_CLK) @(negedge clk);
        check_out("after break", 8'h01, 1'b0, 1'b1, 1'b0);
        idle(BIT_CLK);
        send_frame(8'h81, 1'b1);
        check_out("post-break frame", 8'h81, 1'b1, 1'b0, 1'b0);
        pulse_ack();
        check("post-break ack valid", 32'(rx_valid), 32'd0);

        // Back-to-back frames without ack: second byte lost.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_out("b2b", 8'h11, 1'b1, 1'b0, 1'b1);
        idle(16);
        pulse_ack();
        check_out("b2b ack", 8'h11, 1'b0, 1'b0, 1'b0);

        // Ack in the exact completion cycle of the second frame.
        send_frame(8'h55, 1'b1);
        idle(BIT_CLK);
        fork
            send_frame(8'hAA, 1'b1);
            watch_done(1'b1, found, pre_v, pre_d, post_v);
        join
        check("ackdone found", 32'(found), 32'd1);
        check("ackdone pre valid", 32'(pre_v), 32'd1);
        check("ackdone pre data", 32'(pre_d), 32'h55);
        check("ackdone post valid", 32'(post_v), 32'd1);
        check_out("ackdone", 8'hAA, 1'b1, 1'b0, 1'b0);
        idle(BIT_CLK);

        // One-cycle reset during data bit 4 of 0xFF, then a clean frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
                n_rst = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
                check_out("mid-frame reset", 8'h00, 1'b0, 1'b0, 1'b0);
            end
        join
        check_out("aborted frame", 8'h00, 1'b0, 1'b0, 1'b0);
        idle(BIT_CLK);
        send_frame(8'h0F, 1'b1);
        check_out("after reset frame", 8'h0F, 1'b1, 1'b0, 1'b0);

        // Random frames against a frame-level model of the output register.
        m_data = 8'h0F; m_valid = 1'b1; m_ferr = 1'b0; m_ovr = 1'b0;
        for (int i = 0; i < N_RAND; i++) begin
            r_data = 8'($urandom);
            r_stop = ($urandom_range(0, 7) != 0);
            send_frame(r_data, r_stop);
            if (r_stop) begin
                m_ferr = 1'b0;
                if (!m_valid) begin
                    m_data  = r_data;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                m_ferr = 1'b1;
            end
            check_out($sformatf("rand%0d", i), m_data, m_valid, m_ferr, m_ovr);
            idle(int'($urandom_range(16, 80)));
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                if (m_valid) begin
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
                check($sformatf("rand%0d ack valid", i), 32'(rx_valid), 32'(m_valid));
                check($sformatf("rand%0d ack overrun", i), 32'(overrun), 32'(m_ovr));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the `tx` transmitter: it consumes the `txd` line, or any 8N1 line at the same bit rate, and recovers bytes. The line is oversampled by a strobe `rxen` that pulses OSR times per bit period. A synchronizer and start-bit validation sit in front, and the recovered byte is presented on a valid/ack register interface to the core logic.

## Interface
Parameters:
- `OSR`, default 16: `rxen` ticks per bit period; even, ≥ 4.
- `DATA_W`, default 8: data bits per frame, sent LSB first.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `n_rst`  in  1: reset, synchronous and active-low.
- `rxd`  in  1: asynchronous serial line, idle high.
- `rxen`  in  1: oversample strobe, one `clk` wide, OSR pulses per bit.
- `rx_ack`  in  1: consumer accepts `rx_data` in this cycle.
- `rx_data`  out  DATA_W: last accepted byte.
- `rx_valid`  out  1: `rx_data` holds an unconsumed byte.
- `frame_err`  out  1: last frame had stop bit = 0.
- `overrun`  out  1: sticky; a byte was lost because `rx_valid` was still set.

## Operation
- `rxd` passes through a 2-flop synchronizer to give `rxd_s`. Reset value of `rxd_s` is 1.
- FSM states are IDLE, START, DATA, STOP. Sample counter `s_cnt` (log2 OSR bits) and bit counter `b_cnt` (log2 DATA_W + 1 bits) advance only on `rxen` cycles. When `rxen` = 0, state and all counters hold.
- IDLE:
  - `armed` is set on any `rxen` cycle with `rxd_s` = 1.
  - `rxen` cycle with `armed` and `rxd_s` = 0 → START, `s_cnt` = 0.
- START:
  - At `s_cnt` = OSR/2−1 (bit centre), sample `rxd_s`.
  - Sample = 1 → IDLE. This is a glitch: no flag, `armed` stays set.
  - Sample = 0 → DATA, `s_cnt` = 0, `b_cnt` = 0.
- DATA:
  - At `s_cnt` = OSR−1: `shreg` = {`rxd_s`, `shreg`[DATA_W−1:1]}, `b_cnt`++, `s_cnt` wraps to 0.
  - After bit DATA_W−1 → STOP.
- STOP:
  - At `s_cnt` = OSR−1, sample `rxd_s` and go to IDLE with `armed` = 0.
  - Sample = 1: frame good, `frame_err` ← 0. Delivery then follows the handshake rules below.
  - Sample = 0: `frame_err` ← 1, the byte is discarded, and `rx_data` and `rx_valid` are unchanged. Because `armed` = 0, a held-low line (break) never starts a new frame until `rxd_s` returns high.
- Handshake on a good-frame completion:
  - `rx_valid` = 0: load `rx_data`, set `rx_valid` = 1.
  - `rx_valid` = 1 and `rx_ack` = 0: the new byte is dropped, the old `rx_data` is kept, `overrun` ← 1.
  - `rx_valid` = 1 and `rx_ack` = 1 in the same cycle: load the new byte, keep `rx_valid` = 1, no overrun.
- Handshake otherwise:
  - `rx_ack` while `rx_valid` = 1 clears `rx_valid` and `overrun` at the next edge.
  - `rx_ack` while `rx_valid` = 0 is ignored.
- Reset values: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0. State = IDLE, `armed` = 0, `s_cnt` = 0, `b_cnt` = 0, `shreg` = 0.
- Reset asserted mid-frame aborts the frame at the next edge. No partial byte is ever delivered.

## Timing
- Synchronizer latency is 2 `clk` cycles from the `rxd` edge to `rxd_s`.
- Start detection happens on the first `rxen` cycle after `rxd_s` falls.
- Data bit k is sampled (1 + k)·OSR + OSR/2 ticks after start detection, i.e. at the bit centre.
- `rx_valid` and `frame_err` update on the clock edge ending the stop-sample `rxen` cycle. That is 1 `clk` cycle after the sample, with no further pipeline.
- The receiver is back in IDLE at the stop-bit centre, giving OSR/2 ticks of slack for back-to-back frames and tolerating about ±4 % rate mismatch at OSR = 16.
- `rx_ack` is acted on in the same cycle it is high, independent of `rxen`.

## Structure
- Shared package `uart_pkg` holds:
  - state encoding constants ST_IDLE = 0, ST_START = 1, ST_DATA = 2, ST_STOP = 3;
  - default OSR and DATA_W;
  - FRAME_BITS = DATA_W + 2.
  - These are shared with the transmitter.
- One sub-module, `uart_sync2`: a 2-flop synchronizer with a reset value parameter (1 here).
- Everything else lives in `uart_rx`: FSM, counters, shift register and output register.

## Test plan
Defaults apply: OSR = 16, DATA_W = 8, `rxen` every 4th `clk`, bit = 64 `clk`.
- Single frame 0xA5 sent 8N1, no ack → `rx_data` = 0xA5, `rx_valid` = 1, `frame_err` = 0, `overrun` = 0, with `rx_valid` rising 1 cycle after the stop-centre tick. Then ack → `rx_valid` = 0 next cycle.
- 20-cycle low glitch on idle `rxd` → no state leaves IDLE after the mid-start check, `rx_valid` = 0, `frame_err` = 0.
- Frame 0x3C with stop bit = 0, then line held low for 30 bits, then a good frame 0x81 → `frame_err` = 1 and no valid for the first; nothing during the break; then `rx_data` = 0x81 with `frame_err` = 0.
- Back-to-back 0x11 and 0x22 with no ack → `rx_data` = 0x11, `overrun` = 1. A subsequent ack clears `rx_valid` and `overrun`.
- 0x55 then 0xAA, with ack asserted exactly on the 0xAA completion cycle → `rx_data` = 0xAA, `rx_valid` stays 1, `overrun` = 0.
- `n_rst` low for 1 cycle during data bit 4 of 0xFF, then a clean 0x0F → outputs return to reset values, and only 0x0F is delivered.
